mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 128-bit line-wide memory port between the instruction-cache controller and the data-cache controller.
- Each cache controller drives a private memory-style interface into this block. The block picks one requester, forwards its transaction to memory, and returns mem_ready only to the granted requester.
- Sits between the two cache_controller instances and the off-chip memory model, at the top level of the CPU+cache system.

Parameters:
ADDR_W, 28, memory line-address width (word address >> 2)
DATA_W, 128, cache line width in bits

Ports:
clk  in  1  system clock
proc_reset_i  in  1  synchronous active-high reset
i_read_i  in  1  I-cache line read request
i_write_i  in  1  I-cache line write request (tied 0 normally, still arbitrated)
i_addr_i  in  ADDR_W  I-cache line address
i_wdata_i  in  DATA_W  I-cache write line
i_rdata_o  out  DATA_W  read line to I-cache
i_ready_o  out  1  I-cache transaction done
d_read_i  in  1  D-cache line read request
d_write_i  in  1  D-cache line write request
d_addr_i  in  ADDR_W  D-cache line address
d_wdata_i  in  DATA_W  D-cache write line
d_rdata_o  out  DATA_W  read line to D-cache
d_ready_o  out  1  D-cache transaction done
mem_read_o  out  1  memory read strobe
mem_write_o  out  1  memory write strobe
mem_addr_o  out  ADDR_W  memory line address
mem_wdata_o  out  DATA_W  memory write line
mem_rdata_i  in  DATA_W  memory read line
mem_ready_i  in  1  memory done, one-cycle pulse

Behaviour:
- Clock and reset: one clock, clk. proc_reset_i is synchronous and active-high.
- Reset values:
  - state = IDLE; last_grant = D, so the first tie goes to I.
  - mem_read_o = mem_write_o = 0; mem_addr_o = 0; mem_wdata_o = 0.
  - i_ready_o = d_ready_o = 0.
- Requester protocol (same as the cache controller): the strobe is held high with stable addr/wdata until the matching ready pulse. read and write together from one requester is illegal; write wins and the read is ignored.
- States: IDLE, GNT_I, GNT_D.
- IDLE:
  - No memory strobes.
  - req_x = x_read_i | x_write_i.
  - Only one of req_i/req_d set: go to that grant state next cycle.
  - Both set: round-robin, granting the requester that is not last_grant. last_grant updates on entry to a grant state.
  - mem_ready_i in IDLE is ignored.
- GNT_x:
  - mem_read_o, mem_write_o, mem_addr_o and mem_wdata_o combinationally mirror requester x's inputs.
  - The other requester's inputs are ignored.
- On mem_ready_i in GNT_x:
  - x_ready_o = 1 the same cycle, combinational pass-through.
  - Next state IDLE.
- Requester x drops its strobe while in GNT_x before ready (abort, e.g. that cache reset): strobes drop immediately, next state IDLE; any late mem_ready_i is ignored.
- x_rdata_o = mem_rdata_i for both requesters (broadcast). Only the ready signals are gated.
- Latency: a request seen in IDLE at cycle t gives a memory strobe at t+1. Ready returns the same cycle as mem_ready_i. There is a mandatory one-cycle IDLE gap between back-to-back grants.
- Reset asserted mid-grant: state returns to IDLE on that edge, strobes drop, and the in-flight transaction is discarded.
- Fairness: with continuous requests from both sides, grants strictly alternate I, D, I, D.

Optional Feature:
Macro WB_LOCK_EN.
- Defined: after a write transaction by x completes, the next IDLE cycle grants x again if req_x is set, regardless of round-robin. This keeps a dirty-line writeback and its refill read back-to-back; last_grant is not updated by a locked grant.
- Undefined: pure round-robin as above.

Decomposition:
- Package mem_arb_pkg holds:
  - the state localparams (IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2);
  - the requester-ID constants REQ_I = 1'b0 and REQ_D = 1'b1;
  - ADDR_W/DATA_W defaults.
- No sub-module. A single FSM plus muxes, roughly 150 lines of RTL.

Test Plan:
- Reset, then only d_read_i = 1, d_addr_i = 28'h0000010 → mem_read_o = 1 and mem_addr_o = 28'h0000010 one cycle later. mem_ready_i pulse with mem_rdata_i = 128'hDEAD…BEEF → d_ready_o = 1 that cycle, d_rdata_o matches, i_ready_o stays 0.
- i_read_i and d_read_i rise together right after reset → I granted first, D granted after I's ready plus one IDLE cycle. Continuous requests for 4 transactions give grant order I, D, I, D.
- D writeback: d_write_i = 1, d_addr_i = 28'h00000A4, d_wdata_i = 128'h1111… → mem_write_o = 1 with the same address and data. Then D switches to read while I requests: I is granted next without WB_LOCK_EN, D is granted next with WB_LOCK_EN.
- mem_ready_i pulsed in IDLE and while the other side is granted → no ready appears on either requester port.
- proc_reset_i asserted during GNT_D with memory busy → next cycle state IDLE, all strobes 0; a later mem_ready_i is ignored and normal arbitration resumes.
- D drops d_read_i mid-grant (abort) → mem_read_o = 0 the same cycle; a pending i_read_i is granted two cycles later.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encodings, requester IDs and default widths for mem_arbiter
package mem_arb_pkg;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] GNT_I = 2'd1;
   localparam logic [1:0] GNT_D = 2'd2;
   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;
   localparam int DEF_ADDR_W = 28;
   localparam int DEF_DATA_W = 128;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one line-wide memory port between I- and D-cache
// WB_LOCK_EN: after a completed write, the same requester is regranted on the next IDLE cycle
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              proc_reset_i,
   input  logic              i_read_i,
   input  logic              i_write_i,
   input  logic [ADDR_W-1:0] i_addr_i,
   input  logic [DATA_W-1:0] i_wdata_i,
   output logic [DATA_W-1:0] i_rdata_o,
   output logic              i_ready_o,
   input  logic              d_read_i,
   input  logic              d_write_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_ready_o,
   output logic              mem_read_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ready_i
);
   logic [1:0] state;
   logic last_grant, lock_hit, lock_id, pick, gi, gd, req_i, req_d;
   always_comb begin
      gi = state == GNT_I;
      gd = state == GNT_D;
      req_i = i_read_i | i_write_i;
      req_d = d_read_i | d_write_i;
      mem_read_o = gi ? i_read_i & ~i_write_i : gd ? d_read_i & ~d_write_i : 1'b0;
      mem_write_o = gi ? i_write_i : gd ? d_write_i : 1'b0;
      mem_addr_o = gi ? i_addr_i : gd ? d_addr_i : '0;
      mem_wdata_o = gi ? i_wdata_i : gd ? d_wdata_i : '0;
      i_ready_o = gi & req_i & mem_ready_i;
      d_ready_o = gd & req_d & mem_ready_i;
      i_rdata_o = mem_rdata_i;
      d_rdata_o = mem_rdata_i;
      pick = lock_hit ? lock_id : (req_i & req_d) ? ~last_grant : req_d ? REQ_D : REQ_I;
   end
`ifdef WB_LOCK_EN
   logic lock_v;
   assign lock_hit = lock_v & (lock_id == REQ_D ? req_d : req_i);
   // the lock lives only until the first IDLE cycle after the write completes
   always_ff @(posedge clk) begin
      if (proc_reset_i || state == IDLE) begin
         lock_v <= 1'b0;
         lock_id <= REQ_I;
      end else if ((i_ready_o & i_write_i) | (d_ready_o & d_write_i)) begin
         lock_v <= 1'b1;
         lock_id <= gd ? REQ_D : REQ_I;
      end
   end
`else
   assign lock_hit = 1'b0;
   assign lock_id = REQ_I;
`endif
   always_ff @(posedge clk) begin
      if (proc_reset_i) begin
         state <= IDLE;
         last_grant <= REQ_D;
      end else begin
         case (state)
            IDLE: if (req_i | req_d) begin
               state <= pick == REQ_D ? GNT_D : GNT_I;
               if (!lock_hit) last_grant <= pick;
            end
            GNT_I: if (!req_i || mem_ready_i) state <= IDLE;
            GNT_D: if (!req_d || mem_ready_i) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven per-cycle check of mem_arbiter grants, strobes and ready gating
module tb_mem_arbiter;
   localparam int AW = 28;
   localparam int DW = 128;
`ifdef WB_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif
   localparam logic [AW-1:0] I_A = 28'h0000200;
   localparam logic [DW-1:0] I_WD = {8{16'h2222}};
   localparam logic [DW-1:0] D_WD = {8{16'h1111}};

   typedef struct packed {
      logic [5:0] in;
      logic [1:0] st;
      logic [1:0] sel;
      logic [1:0] rdy;
   } vec_t;

   logic clk = 1'b0;
   logic proc_reset_i, i_read_i, i_write_i, d_read_i, d_write_i, mem_ready_i;
   logic [AW-1:0] i_addr_i, d_addr_i, mem_addr_o;
   logic [DW-1:0] i_wdata_i, d_wdata_i, mem_rdata_i, i_rdata_o, d_rdata_o, mem_wdata_o;
   logic i_ready_o, d_ready_o, mem_read_o, mem_write_o;
   int n_chk = 0;
   int n_fail = 0;
   vec_t vecs[48];

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .proc_reset_i(proc_reset_i),
      .i_read_i(i_read_i), .i_write_i(i_write_i), .i_addr_i(i_addr_i), .i_wdata_i(i_wdata_i),
      .i_rdata_o(i_rdata_o), .i_ready_o(i_ready_o),
      .d_read_i(d_read_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
      .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
   );

   function automatic vec_t mk(logic [5:0] in, logic [1:0] st, logic [1:0] sel, logic [1:0] rdy);
      mk = '{in: in, st: st, sel: sel, rdy: rdy};
   endfunction

   task automatic chk(input string name, input int row, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   initial begin
      logic [1:0] g1, r1, g2, r2;
      logic [AW-1:0] ea;
      logic [DW-1:0] ew;
      g1 = LOCK ? 2'd2 : 2'd1;
      r1 = LOCK ? 2'b01 : 2'b10;
      g2 = LOCK ? 2'd1 : 2'd2;
      r2 = LOCK ? 2'b10 : 2'b01;
      // in = {rst, ir, iw, dr, dw, mr}; st = {mem_read, mem_write}; sel 1=I 2=D; rdy = {i_ready, d_ready}
      vecs[0] = mk(6'b100000, 2'b00, 2'd0, 2'b00);
      vecs[1] = mk(6'b000100, 2'b00, 2'd0, 2'b00);
      vecs[2] = mk(6'b000100, 2'b10, 2'd2, 2'b00);
      vecs[3] = mk(6'b000101, 2'b10, 2'd2, 2'b01);
      vecs[4] = mk(6'b000000, 2'b00, 2'd0, 2'b00);
      vecs[5] = mk(6'b100000, 2'b00, 2'd0, 2'b00);
      vecs[6] = mk(6'b010100, 2'b00, 2'd0, 2'b00);
      vecs[7] = mk(6'b010100, 2'b10, 2'd1, 2'b00);
      vecs[8] = mk(6'b010101, 2'b10, 2'd1, 2'b10);
      vecs[9] = mk(6'b010100, 2'b00, 2'd0, 2'b00);
      vecs[10] = mk(6'b010100, 2'b10, 2'd2, 2'b00);
      vecs[11] = mk(6'b010101, 2'b10, 2'd2, 2'b01);
      vecs[12] = mk(6'b010100, 2'b00, 2'd0, 2'b00);
      vecs[13] = mk(6'b010100, 2'b10, 2'd1, 2'b00);
      vecs[14] = mk(6'b010101, 2'b10, 2'd1, 2'b10);
      vecs[15] = mk(6'b010100, 2'b00, 2'd0, 2'b00);
      vecs[16] = mk(6'b010101, 2'b10, 2'd2, 2'b01);
      vecs[17] = mk(6'b000001, 2'b00, 2'd0, 2'b00);
      vecs[18] = mk(6'b000010, 2'b00, 2'd0, 2'b00);
      vecs[19] = mk(6'b000010, 2'b01, 2'd2, 2'b00);
      vecs[20] = mk(6'b010011, 2'b01, 2'd2, 2'b01);
      vecs[21] = mk(6'b010100, 2'b00, 2'd0, 2'b00);
      vecs[22] = mk(6'b010101, 2'b10, g1, r1);
      vecs[23] = mk(6'b010100, 2'b00, 2'd0, 2'b00);
      vecs[24] = mk(6'b010101, 2'b10, g2, r2);
      vecs[25] = mk(6'b000000, 2'b00, 2'd0, 2'b00);
      vecs[26] = mk(6'b000100, 2'b00, 2'd0, 2'b00);
      vecs[27] = mk(6'b000100, 2'b10, 2'd2, 2'b00);
      vecs[28] = mk(6'b100100, 2'b10, 2'd2, 2'b00);
      vecs[29] = mk(6'b000001, 2'b00, 2'd0, 2'b00);
      vecs[30] = mk(6'b010000, 2'b00, 2'd0, 2'b00);
      vecs[31] = mk(6'b010001, 2'b10, 2'd1, 2'b10);
      vecs[32] = mk(6'b000000, 2'b00, 2'd0, 2'b00);
      vecs[33] = mk(6'b000100, 2'b00, 2'd0, 2'b00);
      vecs[34] = mk(6'b010100, 2'b10, 2'd2, 2'b00);
      vecs[35] = mk(6'b010000, 2'b00, 2'd2, 2'b00);
      vecs[36] = mk(6'b010001, 2'b00, 2'd0, 2'b00);
      vecs[37] = mk(6'b010000, 2'b10, 2'd1, 2'b00);
      vecs[38] = mk(6'b010001, 2'b10, 2'd1, 2'b10);
      vecs[39] = mk(6'b000000, 2'b00, 2'd0, 2'b00);
      vecs[40] = mk(6'b000110, 2'b00, 2'd0, 2'b00);
      vecs[41] = mk(6'b000110, 2'b01, 2'd2, 2'b00);
      vecs[42] = mk(6'b000111, 2'b01, 2'd2, 2'b01);
      vecs[43] = mk(6'b000000, 2'b00, 2'd0, 2'b00);
      vecs[44] = mk(6'b001000, 2'b00, 2'd0, 2'b00);
      vecs[45] = mk(6'b001000, 2'b01, 2'd1, 2'b00);
      vecs[46] = mk(6'b001001, 2'b01, 2'd1, 2'b10);
      vecs[47] = mk(6'b000000, 2'b00, 2'd0, 2'b00);
      proc_reset_i = 1'b1;
      {i_read_i, i_write_i, d_read_i, d_write_i, mem_ready_i} = '0;
      i_addr_i = I_A;
      d_addr_i = 28'h0000010;
      i_wdata_i = I_WD;
      d_wdata_i = D_WD;
      mem_rdata_i = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;
      repeat (2) @(posedge clk);
      for (int k = 0; k < 48; k++) begin
         @(negedge clk);
         {proc_reset_i, i_read_i, i_write_i, d_read_i, d_write_i, mem_ready_i} = vecs[k].in;
         d_addr_i = k < 5 ? 28'h0000010 : 28'h00000A4;
         if (k > 3) mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
         #1;
         ea = vecs[k].sel == 2'd1 ? I_A : vecs[k].sel == 2'd2 ? d_addr_i : '0;
         ew = vecs[k].sel == 2'd1 ? I_WD : vecs[k].sel == 2'd2 ? D_WD : '0;
         chk("mem_read", k, DW'(mem_read_o), DW'(vecs[k].st[1]));
         chk("mem_write", k, DW'(mem_write_o), DW'(vecs[k].st[0]));
         chk("mem_addr", k, DW'(mem_addr_o), DW'(ea));
         chk("mem_wdata", k, mem_wdata_o, ew);
         chk("i_ready", k, DW'(i_ready_o), DW'(vecs[k].rdy[1]));
         chk("d_ready", k, DW'(d_ready_o), DW'(vecs[k].rdy[0]));
         chk("i_rdata", k, i_rdata_o, mem_rdata_i);
         chk("d_rdata", k, d_rdata_o, mem_rdata_i);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
